// File: rtl/exibidor_sequencia_if.sv
// Control/memory bus of the sequence playback engine: start/abort request, RAM read port,
// and LED/buzzer/status outputs. master = control unit + RAM side, slave = exibidor_sequencia.
interface exibidor_sequencia_if;
  logic       iniciar;
  logic       abortar;
  logic [3:0] ultimo;
  logic [3:0] mem_data;
  logic [3:0] mem_addr;
  logic [3:0] leds;
  logic       toca;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  modport master (
    output iniciar, abortar, ultimo, mem_data,
    input  mem_addr, leds, toca, ocupado, pronto, db_estado
  );

  modport slave (
    input  iniciar, abortar, ultimo, mem_data,
    output mem_addr, leds, toca, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exibidor_sequencia.sv
// Sequence playback engine: reads RAM addresses 0..ultimo, lights each word for ON_CYCLES then
// stays dark for OFF_CYCLES. Optional EXIBIDOR_RAPIDO_EN adds a 'rapido' port halving both times.
module exibidor_sequencia #(
  parameter int ON_CYCLES  = 2500,
  parameter int OFF_CYCLES = 1250
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef EXIBIDOR_RAPIDO_EN
  input  logic                 rapido,
`endif
  exibidor_sequencia_if.slave  bus
);

  localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW         = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
`ifdef EXIBIDOR_RAPIDO_EN
  localparam int ON_HALF  = (ON_CYCLES / 2 < 1) ? 1 : ON_CYCLES / 2;
  localparam int OFF_HALF = (OFF_CYCLES / 2 < 1) ? 1 : OFF_CYCLES / 2;
  localparam logic [TW-1:0] ON_LAST_R  = TW'(ON_HALF - 1);
  localparam logic [TW-1:0] OFF_LAST_R = TW'(OFF_HALF - 1);
`endif

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ENDERECA = 3'd1,
    CARREGA  = 3'd2,
    ACESO    = 3'd3,
    APAGADO  = 3'd4,
    FIM      = 3'd5
  } estado_t;

  estado_t       estado, estado_next;
  logic [3:0]    addr, addr_next;
  logic [3:0]    ult_reg, ult_next;
  logic [3:0]    dado_reg, dado_next;
  logic [TW-1:0] timer, timer_next;
  logic [TW-1:0] on_last, off_last;
`ifdef EXIBIDOR_RAPIDO_EN
  logic          rap_reg, rap_next;
`endif

  always_comb begin
`ifdef EXIBIDOR_RAPIDO_EN
    on_last  = rap_reg ? ON_LAST_R  : ON_LAST;
    off_last = rap_reg ? OFF_LAST_R : OFF_LAST;
`else
    on_last  = ON_LAST;
    off_last = OFF_LAST;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= OCIOSO;
      addr     <= '0;
      ult_reg  <= '0;
      dado_reg <= '0;
      timer    <= '0;
`ifdef EXIBIDOR_RAPIDO_EN
      rap_reg  <= 1'b0;
`endif
    end else begin
      estado   <= estado_next;
      addr     <= addr_next;
      ult_reg  <= ult_next;
      dado_reg <= dado_next;
      timer    <= timer_next;
`ifdef EXIBIDOR_RAPIDO_EN
      rap_reg  <= rap_next;
`endif
    end
  end

  always_comb begin
    estado_next = estado;
    addr_next   = addr;
    ult_next    = ult_reg;
    dado_next   = dado_reg;
    timer_next  = timer;
`ifdef EXIBIDOR_RAPIDO_EN
    rap_next    = rap_reg;
`endif
    // Abort takes priority over every in-progress state; mem_addr is left as is.
    if (estado != OCIOSO && bus.abortar) begin
      estado_next = OCIOSO;
    end else begin
      case (estado)
        OCIOSO: begin
          if (bus.iniciar && !bus.abortar) begin
            addr_next   = '0;
            ult_next    = bus.ultimo;
`ifdef EXIBIDOR_RAPIDO_EN
            rap_next    = rapido;
`endif
            estado_next = ENDERECA;
          end
        end
        ENDERECA: estado_next = CARREGA;
        CARREGA: begin
          dado_next   = bus.mem_data;
          timer_next  = '0;
          estado_next = ACESO;
        end
        ACESO: begin
          if (timer == on_last) begin
            timer_next  = '0;
            estado_next = APAGADO;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        APAGADO: begin
          if (timer == off_last) begin
            timer_next = '0;
            if (addr == ult_reg) begin
              estado_next = FIM;
            end else begin
              addr_next   = addr + 4'd1;
              estado_next = ENDERECA;
            end
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        FIM:     estado_next = OCIOSO;
        default: estado_next = OCIOSO;
      endcase
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.leds      = (estado == ACESO) ? dado_reg : '0;
  assign bus.toca      = (estado == ACESO) && (dado_reg != 4'd0);
  assign bus.ocupado   = (estado == ENDERECA) || (estado == CARREGA) ||
                         (estado == ACESO)    || (estado == APAGADO);
  assign bus.pronto    = (estado == FIM);
  assign bus.db_estado = estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Directed bench for exibidor_sequencia with ON_CYCLES=4, OFF_CYCLES=2 and a 1-cycle-latency RAM.
module tb_exibidor_sequencia;
  logic clock;
  logic reset;
`ifdef EXIBIDOR_RAPIDO_EN
  logic rapido;
`endif
  logic [3:0] ram [16];
  int tests;
  int fails;

  exibidor_sequencia_if bus ();

  exibidor_sequencia #(.ON_CYCLES(4), .OFF_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
`ifdef EXIBIDOR_RAPIDO_EN
    .rapido(rapido),
`endif
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) bus.mem_data <= ram[bus.mem_addr];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Plays one sequence; cycle c is the cycle after the c-th edge following the start edge.
  task automatic play(input int ult, input int on, input int off, input int abort_at, input int repulse_at);
    int per;
    int last;
    int w;
    int p;
    logic [7:0] est, el, et, eo, ep, ea;
    per  = 2 + on + off;
    last = 1 + (ult + 1) * per;
    bus.ultimo  = ult[3:0];
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    bus.ultimo  = ~ult[3:0];
    for (int c = 1; c <= last + 1; c++) begin
      w = (c - 1) / per;
      p = (c - 1) % per;
      eo = 8'd1; ep = 8'd0; ea = w[7:0];
      if (c == last) begin
        est = 8'd5; eo = 8'd0; ep = 8'd1; ea = ult[7:0];
      end else if (c == last + 1) begin
        est = 8'd0; eo = 8'd0; ea = ult[7:0];
      end else if (p == 0) est = 8'd1;
      else if (p == 1) est = 8'd2;
      else if (p < 2 + on) est = 8'd3;
      else est = 8'd4;
      el = (est == 8'd3) ? {4'd0, ram[w]} : 8'd0;
      et = (est == 8'd3 && ram[w] != 4'd0) ? 8'd1 : 8'd0;
      if (abort_at > 0 && c > abort_at) begin
        est = 8'd0; el = 8'd0; et = 8'd0; eo = 8'd0; ep = 8'd0;
      end else begin
        check($sformatf("u%0d c%0d mem_addr", ult, c), {4'd0, bus.mem_addr}, ea);
      end
      check($sformatf("u%0d c%0d db_estado", ult, c), {5'd0, bus.db_estado}, est);
      check($sformatf("u%0d c%0d leds", ult, c), {4'd0, bus.leds}, el);
      check($sformatf("u%0d c%0d toca", ult, c), {7'd0, bus.toca}, et);
      check($sformatf("u%0d c%0d ocupado", ult, c), {7'd0, bus.ocupado}, eo);
      check($sformatf("u%0d c%0d pronto", ult, c), {7'd0, bus.pronto}, ep);
      bus.abortar = (c == abort_at);
      bus.iniciar = (c == repulse_at);
      tick();
    end
    bus.abortar = 1'b0;
    bus.iniciar = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) ram[i] = 4'd0;
    bus.iniciar = 1'b0;
    bus.abortar = 1'b0;
    bus.ultimo  = 4'd0;
`ifdef EXIBIDOR_RAPIDO_EN
    rapido = 1'b0;
`endif

    // 1: reset held 3 cycles with iniciar asserted
    reset = 1'b1;
    bus.iniciar = 1'b1;
    bus.ultimo  = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst db_estado", {5'd0, bus.db_estado}, 8'd0);
      check("rst leds", {4'd0, bus.leds}, 8'd0);
      check("rst mem_addr", {4'd0, bus.mem_addr}, 8'd0);
      check("rst flags", {5'd0, bus.toca, bus.ocupado, bus.pronto}, 8'd0);
    end
    reset = 1'b0;
    bus.iniciar = 1'b0;
    tick();
    check("post-rst db_estado", {5'd0, bus.db_estado}, 8'd0);
    check("post-rst ocupado", {7'd0, bus.ocupado}, 8'd0);
    tick();

    // 2: four words 1,2,4,8
    ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4; ram[3] = 4'd8;
    play(3, 4, 2, 0, 0);
    tick();

    // 3: single word
    ram[0] = 4'd5;
    play(0, 4, 2, 0, 0);
    tick();

    // 4: abort in cycle 12, then restart from address 0
    ram[0] = 4'd1;
    play(3, 4, 2, 12, 0);
    check("abort pronto", {7'd0, bus.pronto}, 8'd0);
    play(3, 4, 2, 0, 0);
    tick();

    // 5: sixteen words 0..15, re-pulse iniciar and change ultimo mid-run
    for (int i = 0; i < 16; i++) ram[i] = i[3:0];
    play(15, 4, 2, 0, 40);
    check("full mem_addr final", {4'd0, bus.mem_addr}, 8'd15);
    tick();

`ifdef EXIBIDOR_RAPIDO_EN
    // 6: fast mode latched at start
    rapido = 1'b1;
    play(1, 2, 1, 0, 0);
    rapido = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
